// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings and helpers for the DMEM port arbiter and its lane generator.
package dmem_port_arbiter_pkg;

    // Width of one DMEM word.
    localparam int DMEM_DW = 32;

    // CPU access size encoding as presented on cpu_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Owner of the read that is in flight through the block RAM.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_LDR  = 2'b10
    } owner_e;

    // True when the access size and byte offset do not form a naturally aligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, loader and DMEM port signals around the arbiter.
// master: the environment driving requests; slave: the arbiter itself.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    import dmem_port_arbiter_pkg::*;

    logic                 boot_mode;

    logic                 cpu_req;
    logic                 cpu_we;
    logic [1:0]           cpu_size;
    logic [31:0]          cpu_addr;
    logic [DMEM_DW-1:0]   cpu_wdata;
    logic                 cpu_stall;
    logic                 cpu_rvalid;
    logic                 misalign_err;

    logic                 ldr_valid;
    logic                 ldr_ready;
    logic                 ldr_we;
    logic [ADDR_W-1:0]    ldr_addr;
    logic [DMEM_DW-1:0]   ldr_wdata;
    logic                 ldr_rvalid;

    logic                 dmem_ena;
    logic [3:0]           dmem_wea;
    logic [ADDR_W-1:0]    dmem_addra;
    logic [DMEM_DW-1:0]   dmem_dina;

    modport master (
        output boot_mode,
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, misalign_err,
        output ldr_valid, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_ready, ldr_rvalid,
        input  dmem_ena, dmem_wea, dmem_addra, dmem_dina
    );

    modport slave (
        input  boot_mode,
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, misalign_err,
        input  ldr_valid, ldr_we, ldr_addr, ldr_wdata,
        output ldr_ready, ldr_rvalid,
        output dmem_ena, dmem_wea, dmem_addra, dmem_dina
    );

endinterface

// File: rtl/dmem_port_arbiter_store_lane_gen.sv
// Big-endian byte-lane mapper: turns CPU size, byte offset and right-aligned
// store data into DMEM byte enables and lane-replicated write data.
// Lane 3 (wea[3]) is bits [31:24], i.e. byte offset 0.
module dmem_port_arbiter_store_lane_gen
    import dmem_port_arbiter_pkg::*;
(
    input  logic               we_i,
    input  logic [1:0]         size_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [DMEM_DW-1:0] wdata_i,
    output logic [3:0]         wea_o,
    output logic [DMEM_DW-1:0] dina_o,
    output logic               misalign_o
);

    logic [3:0] lane_s;
    logic       mis_s;

    // Select lanes and replicate data; misaligned or illegal accesses write nothing.
    always_comb begin
        lane_s = 4'b0000;
        dina_o = wdata_i;
        mis_s  = is_misaligned(size_i, addr_lo_i);
        case (size_i)
            SZ_BYTE: begin
                dina_o = {4{wdata_i[7:0]}};
                case (addr_lo_i)
                    2'b00:   lane_s = 4'b1000;
                    2'b01:   lane_s = 4'b0100;
                    2'b10:   lane_s = 4'b0010;
                    default: lane_s = 4'b0001;
                endcase
            end
            SZ_HALF: begin
                dina_o = {2{wdata_i[15:0]}};
                if (addr_lo_i[1]) begin
                    lane_s = 4'b0011;
                end else begin
                    lane_s = 4'b1100;
                end
            end
            SZ_WORD: lane_s = 4'b1111;
            default: lane_s = 4'b0000;
        endcase
        if (we_i && !mis_s) begin
            wea_o = lane_s;
        end else begin
            wea_o = 4'b0000;
        end
        misalign_o = mis_s;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares DMEM port A between the CPU M-stage and a word-wide loader.
// Grant is combinational; the loader is protected from starvation by a
// saturating wait counter, and read ownership is tracked one cycle to match
// block-RAM latency.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 8
)(
    input  logic                clk_i,
    input  logic                rst_ni,
    dmem_port_arbiter_if.slave  bus
);

    localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

    logic [7:0]         starve_cnt_q;
    logic [7:0]         starve_cnt_d;
    owner_e             rd_owner_q;
    owner_e             rd_owner_d;
    logic               misalign_err_q;
    logic               misalign_err_d;

    logic               starved_s;
    logic               cpu_grant_s;
    logic               ldr_grant_s;
    logic [3:0]         lane_wea_s;
    logic [DMEM_DW-1:0] lane_dina_s;
    logic               lane_mis_s;
    logic               cpu_addr_unused_s;

    // Upper CPU address bits lie outside the DMEM and are intentionally ignored.
    assign cpu_addr_unused_s = ^bus.cpu_addr[31:ADDR_W+2];

    assign starved_s = (starve_cnt_q == STARVE_MAX_C);

    dmem_port_arbiter_store_lane_gen u_lane_gen (
        .we_i       (bus.cpu_we),
        .size_i     (bus.cpu_size),
        .addr_lo_i  (bus.cpu_addr[1:0]),
        .wdata_i    (bus.cpu_wdata),
        .wea_o      (lane_wea_s),
        .dina_o     (lane_dina_s),
        .misalign_o (lane_mis_s)
    );

    // Grant decision: boot mode favours the loader, otherwise the CPU unless the loader has starved.
    always_comb begin
        cpu_grant_s = 1'b0;
        ldr_grant_s = 1'b0;
        if (!rst_ni) begin
            cpu_grant_s = 1'b0;
            ldr_grant_s = 1'b0;
        end else if (bus.boot_mode) begin
            ldr_grant_s = bus.ldr_valid;
            cpu_grant_s = bus.cpu_req & ~bus.ldr_valid;
        end else if (bus.cpu_req) begin
            if (starved_s && bus.ldr_valid) begin
                ldr_grant_s = 1'b1;
            end else begin
                cpu_grant_s = 1'b1;
            end
        end else begin
            ldr_grant_s = bus.ldr_valid;
        end
    end

    // Next-state for the starvation counter, read owner and sticky error flag.
    always_comb begin
        starve_cnt_d   = 8'd0;
        rd_owner_d     = OWN_NONE;
        misalign_err_d = misalign_err_q | (cpu_grant_s & lane_mis_s);

        if (bus.ldr_valid && !ldr_grant_s) begin
            if (starved_s) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end else begin
            starve_cnt_d = 8'd0;
        end

        if (cpu_grant_s && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (ldr_grant_s && !bus.ldr_we) begin
            rd_owner_d = OWN_LDR;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // State registers; an asynchronous reset also discards any read in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q   <= 8'd0;
            rd_owner_q     <= OWN_NONE;
            misalign_err_q <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            rd_owner_q     <= rd_owner_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // DMEM port mux driven by whichever requester holds the grant.
    always_comb begin
        bus.dmem_addra = '0;
        bus.dmem_wea   = 4'b0000;
        bus.dmem_dina  = '0;
        if (cpu_grant_s) begin
            bus.dmem_addra = bus.cpu_addr[ADDR_W+1:2];
            bus.dmem_wea   = lane_wea_s;
            bus.dmem_dina  = lane_dina_s;
        end else if (ldr_grant_s) begin
            bus.dmem_addra = bus.ldr_addr;
            bus.dmem_wea   = {4{bus.ldr_we}};
            bus.dmem_dina  = bus.ldr_wdata;
        end else begin
            bus.dmem_addra = '0;
            bus.dmem_wea   = 4'b0000;
            bus.dmem_dina  = '0;
        end
    end

    assign bus.dmem_ena     = cpu_grant_s | ldr_grant_s;
    assign bus.cpu_stall    = rst_ni & bus.cpu_req & ~cpu_grant_s;
    assign bus.ldr_ready    = ldr_grant_s;
    assign bus.cpu_rvalid   = (rd_owner_q == OWN_CPU);
    assign bus.ldr_rvalid   = (rd_owner_q == OWN_LDR);
    assign bus.misalign_err = misalign_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected DMEM
// accesses and read-owner pulses; a monitor pops and compares them.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    typedef struct packed {
        logic [3:0]  wea;
        logic [11:0] addr;
        logic [31:0] dina;
        logic        dina_care;
    } acc_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    acc_t acc_q[$];
    logic [1:0] rd_q[$];   // {cpu_rvalid, ldr_rvalid}

    dmem_port_arbiter_if #(.ADDR_W(12)) bus ();

    dmem_port_arbiter #(.ADDR_W(12), .STARVE_MAX(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_size = sz;
        bus.cpu_addr = addr; bus.cpu_wdata = wd;
    endtask

    task automatic set_ldr(input logic v, input logic we, input logic [11:0] addr,
                           input logic [31:0] wd);
        bus.ldr_valid = v; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wd;
    endtask

    task automatic idle();
        bus.boot_mode = 1'b0;
        set_cpu(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_ldr(1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_acc(input logic [3:0] wea, input logic [11:0] addr,
                           input logic [31:0] dina, input logic care);
        acc_t e;
        e.wea = wea; e.addr = addr; e.dina = dina; e.dina_care = care;
        acc_q.push_back(e);
    endtask

    // One CPU store cycle with no loader traffic.
    task automatic cpu_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] e_wea, input logic [11:0] e_addr,
                             input logic [31:0] e_dina);
        tick();
        idle();
        set_cpu(1'b1, 1'b1, sz, addr, wd);
        exp_acc(e_wea, e_addr, e_dina, 1'b1);
        @(negedge clk);
        chk("store_stall", {31'd0, bus.cpu_stall}, 32'd0);
    endtask

    // Monitor: compare every presented DMEM access and every read-data owner pulse.
    initial begin
        acc_t e;
        logic [1:0] r;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (bus.dmem_ena) begin
                    n_cmp++;
                    if (acc_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL acc_unexpected: got wea=%b addr=%h dina=%h, required no access",
                                 bus.dmem_wea, bus.dmem_addra, bus.dmem_dina);
                    end else begin
                        e = acc_q.pop_front();
                        if (bus.dmem_wea !== e.wea || bus.dmem_addra !== e.addr ||
                            (e.dina_care && bus.dmem_dina !== e.dina)) begin
                            n_fail++;
                            $display("FAIL acc: got wea=%b addr=%h dina=%h, required wea=%b addr=%h dina=%h",
                                     bus.dmem_wea, bus.dmem_addra, bus.dmem_dina, e.wea, e.addr, e.dina);
                        end
                    end
                end
                if (bus.cpu_rvalid || bus.ldr_rvalid) begin
                    n_cmp++;
                    if (rd_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rvalid_unexpected: got cpu=%b ldr=%b, required none",
                                 bus.cpu_rvalid, bus.ldr_rvalid);
                    end else begin
                        r = rd_q.pop_front();
                        if ({bus.cpu_rvalid, bus.ldr_rvalid} !== r) begin
                            n_fail++;
                            $display("FAIL rvalid: got cpu=%b ldr=%b, required cpu=%b ldr=%b",
                                     bus.cpu_rvalid, bus.ldr_rvalid, r[1], r[0]);
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        idle();
        #1 rst_ni = 1'b0;

        // Reset with both requesters active: no grant, no state.
        set_cpu(1'b1, 1'b0, SZ_WORD, 32'h0000_0008, 32'h0);
        set_ldr(1'b1, 1'b0, 12'h001, 32'h0);
        #11;
        chk("rst_ena",      {31'd0, bus.dmem_ena},     32'd0);
        chk("rst_ready",    {31'd0, bus.ldr_ready},    32'd0);
        chk("rst_stall",    {31'd0, bus.cpu_stall},    32'd0);
        chk("rst_cpu_rv",   {31'd0, bus.cpu_rvalid},   32'd0);
        chk("rst_ldr_rv",   {31'd0, bus.ldr_rvalid},   32'd0);
        chk("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        idle();
        @(negedge clk);
        rst_ni = 1'b1;

        // CPU word load at byte 0x8 -> word 2, rvalid to CPU next cycle.
        tick();
        set_cpu(1'b1, 1'b0, SZ_WORD, 32'h0000_0008, 32'h0);
        exp_acc(4'b0000, 12'h002, 32'h0, 1'b0);
        rd_q.push_back(2'b10);
        @(negedge clk);
        chk("load_stall", {31'd0, bus.cpu_stall}, 32'd0);
        tick();
        idle();

        // Lane mapping for aligned stores.
        cpu_store(SZ_BYTE, 32'h0000_0005, 32'h0000_00AB, 4'b0100, 12'h001, 32'hABABABAB);
        cpu_store(SZ_BYTE, 32'h0000_0000, 32'h0000_0011, 4'b1000, 12'h000, 32'h11111111);
        cpu_store(SZ_BYTE, 32'h0000_0003, 32'hFFFF_FF22, 4'b0001, 12'h000, 32'h22222222);
        cpu_store(SZ_HALF, 32'h0000_0002, 32'h0000_1234, 4'b0011, 12'h000, 32'h12341234);
        cpu_store(SZ_HALF, 32'h0000_000C, 32'hAAAA_5678, 4'b1100, 12'h003, 32'h56785678);
        cpu_store(SZ_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 12'h004, 32'hDEADBEEF);
        chk("misalign_clean", {31'd0, bus.misalign_err}, 32'd0);

        // Misaligned word store: granted, no lanes, error registers next edge.
        cpu_store(SZ_WORD, 32'h0000_0006, 32'hCAFE_F00D, 4'b0000, 12'h001, 32'hCAFEF00D);
        chk("misalign_same_cycle", {31'd0, bus.misalign_err}, 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("misalign_set", {31'd0, bus.misalign_err}, 32'd1);

        // Loader write, then loader read followed by a CPU read back-to-back.
        tick();
        set_ldr(1'b1, 1'b1, 12'h123, 32'h1122_3344);
        exp_acc(4'b1111, 12'h123, 32'h11223344, 1'b1);
        @(negedge clk);
        chk("ldr_wr_ready", {31'd0, bus.ldr_ready}, 32'd1);
        tick();
        set_ldr(1'b1, 1'b0, 12'h0AA, 32'h0);
        exp_acc(4'b0000, 12'h0AA, 32'h0, 1'b1);
        rd_q.push_back(2'b01);
        tick();
        idle();
        set_cpu(1'b1, 1'b0, SZ_WORD, 32'h0000_0020, 32'h0);
        exp_acc(4'b0000, 12'h008, 32'h0, 1'b0);
        rd_q.push_back(2'b10);
        tick();
        idle();
        @(negedge clk);
        chk("misalign_sticky", {31'd0, bus.misalign_err}, 32'd1);

        // Starvation: CPU stores every cycle, loader waits; forced grant on cycle 9 only.
        for (int i = 1; i <= 10; i++) begin
            tick();
            set_cpu(1'b1, 1'b1, SZ_WORD, 32'h0000_0040, 32'h55AA_55AA);
            set_ldr(1'b1, 1'b1, 12'h3FF, 32'h0000_0099);
            if (i == 9) begin
                exp_acc(4'b1111, 12'h3FF, 32'h00000099, 1'b1);
            end else begin
                exp_acc(4'b1111, 12'h010, 32'h55AA55AA, 1'b1);
            end
            @(negedge clk);
            chk($sformatf("starve_stall_%0d", i), {31'd0, bus.cpu_stall}, (i == 9) ? 32'd1 : 32'd0);
            chk($sformatf("starve_ready_%0d", i), {31'd0, bus.ldr_ready}, (i == 9) ? 32'd1 : 32'd0);
        end
        tick();
        idle();

        // Boot mode: loader wins every cycle and the CPU stalls.
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.boot_mode = 1'b1;
            set_cpu(1'b1, 1'b0, SZ_WORD, 32'h0000_0080, 32'h0);
            set_ldr(1'b1, 1'b0, 12'h050 + 12'(i), 32'h0);
            exp_acc(4'b0000, 12'h050 + 12'(i), 32'h0, 1'b1);
            rd_q.push_back(2'b01);
            @(negedge clk);
            chk($sformatf("boot_stall_%0d", i), {31'd0, bus.cpu_stall}, 32'd1);
            chk($sformatf("boot_ready_%0d", i), {31'd0, bus.ldr_ready}, 32'd1);
        end

        // Leaving boot mode takes effect in the same cycle.
        tick();
        bus.boot_mode = 1'b0;
        set_ldr(1'b1, 1'b0, 12'h053, 32'h0);
        exp_acc(4'b0000, 12'h020, 32'h0, 1'b0);
        rd_q.push_back(2'b10);
        @(negedge clk);
        chk("unboot_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("unboot_ready", {31'd0, bus.ldr_ready}, 32'd0);

        // Re-enter boot mode; the loader read is then cut off by reset.
        tick();
        bus.boot_mode = 1'b1;
        exp_acc(4'b0000, 12'h053, 32'h0, 1'b1);
        @(negedge clk);
        chk("reboot_stall", {31'd0, bus.cpu_stall}, 32'd1);
        @(posedge clk);
        #2;
        chk("inflight_ldr_rv", {31'd0, bus.ldr_rvalid}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_ena",      {31'd0, bus.dmem_ena},     32'd0);
        chk("midrst_wea",      {28'd0, bus.dmem_wea},     32'd0);
        chk("midrst_addra",    {20'd0, bus.dmem_addra},   32'd0);
        chk("midrst_dina",     bus.dmem_dina,             32'd0);
        chk("midrst_stall",    {31'd0, bus.cpu_stall},    32'd0);
        chk("midrst_ready",    {31'd0, bus.ldr_ready},    32'd0);
        chk("midrst_cpu_rv",   {31'd0, bus.cpu_rvalid},   32'd0);
        chk("midrst_ldr_rv",   {31'd0, bus.ldr_rvalid},   32'd0);
        chk("midrst_misalign", {31'd0, bus.misalign_err}, 32'd0);
        idle();
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_ldr_rv", {31'd0, bus.ldr_rvalid}, 32'd0);
        chk("acc_q_drained", acc_q.size(), 32'd0);
        chk("rd_q_drained",  rd_q.size(),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory block RAM port (DMEM, port A) between two requesters:
  - the CPU M-stage load/store path;
  - a word-wide loader/debug requester, such as a UART program loader.
- Generates big-endian byte-lane write enables from CPU access size and byte address.
- Stalls the CPU when it loses arbitration.
- Tags each granted read so the one-cycle-latency read data is flagged to the correct owner.

Parameters:
- ADDR_W, 12, DMEM word-address width (4K words).
- STARVE_MAX, 8, consecutive loader-wait cycles after which the loader is forced a grant (range 1..255).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- boot_mode  in  1  1 = loader has strict priority over CPU.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- cpu_stall  out  1  CPU must hold its M-stage request this cycle.
- cpu_rvalid  out  1  DMEM read data belongs to the CPU this cycle.
- misalign_err  out  1  sticky; set on misaligned or illegal CPU access.
- ldr_valid  in  1  loader request.
- ldr_ready  out  1  loader request accepted this cycle.
- ldr_we  in  1  loader write (full word).
- ldr_addr  in  ADDR_W  loader word address.
- ldr_wdata  in  32  loader write data.
- ldr_rvalid  out  1  DMEM read data belongs to the loader this cycle.
- dmem_ena  out  1  DMEM port enable.
- dmem_wea  out  4  byte write enables; bit 3 = byte lane [31:24].
- dmem_addra  out  ADDR_W  DMEM word address.
- dmem_dina  out  32  DMEM write data.

Behaviour:
- Reset values (while rst is low, asynchronous):
  - starve_cnt = 0, rd_owner = NONE, misalign_err = 0, cpu_rvalid = 0, ldr_rvalid = 0.
  - Grant outputs are forced 0 while reset is asserted.
- Grant decision is combinational each cycle:
  - boot_mode = 1: loader wins whenever ldr_valid.
  - Otherwise the CPU wins when cpu_req, unless starve_cnt == STARVE_MAX and ldr_valid.
  - With no contention, the sole requester wins.
- Outputs from the grant:
  - cpu_stall = cpu_req & ~cpu_grant.
  - ldr_ready = ldr_grant.
  - dmem_ena = cpu_grant | ldr_grant.
- Starvation counter:
  - Increments when ldr_valid & ~ldr_grant, saturating at STARVE_MAX.
  - Clears on ldr_grant or when ldr_valid = 0.
- CPU-granted access:
  - dmem_addra = cpu_addr[ADDR_W+1:2].
  - Byte store: dina = wdata[7:0] replicated to all four lanes; wea = 1000, 0100, 0010 or 0001 for addr[1:0] = 00, 01, 10, 11.
  - Half store: dina = {wdata[15:0], wdata[15:0]}; wea = 1100 (addr[1] = 0) or 0011 (addr[1] = 1).
  - Word store: wea = 1111.
- Misaligned or illegal CPU access (half with addr[0] = 1, word with addr[1:0] ≠ 00, or size = 11):
  - Access is still granted so the CPU does not hang.
  - wea is forced to 0000 and misalign_err is set (sticky until reset).
- Loader-granted access: dmem_addra = ldr_addr; wea = {4{ldr_we}}; dina = ldr_wdata.
- Read-owner tracking:
  - A granted read registers rd_owner (CPU or LDR).
  - The matching rvalid output pulses exactly 1 cycle later (block-RAM latency).
  - Writes produce no rvalid.
  - Back-to-back reads pipeline at one per cycle.
- Simultaneous forced loader grant and CPU request: CPU stalls exactly one cycle, then regains the port the next cycle because starve_cnt has cleared.
- boot_mode toggling mid-stream takes effect the same cycle; there is no pending state to flush.
- Reset asserted mid-read: the pending rvalid is discarded.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - owner encodings OWN_NONE, OWN_CPU, OWN_LDR;
  - DMEM word width 32.
- One natural sub-module: store_lane_gen (combinational), mapping size, byte address and wdata to wea, dina and the misaligned flag.
  - The same lane mapping is reused later by the load-extract path.

Test Plan:
- CPU-only load at byte 0x0000_0008 → dmem_addra = 2, wea = 0000; cpu_rvalid = 1 the next cycle, ldr_rvalid = 0.
- CPU byte store of 0xAB at address 0x...05 → wea = 0100, dina = 0xABABABAB; no stall.
- CPU half store of 0x1234 at 0x...02 → wea = 0011, dina = 0x12341234.
- CPU word store at 0x...06 → wea = 0000; misalign_err rises the next edge and stays high.
- CPU req held continuously, ldr_valid high, STARVE_MAX = 8 → ldr_ready on the 9th cycle only, cpu_stall high for exactly that cycle.
- boot_mode = 1 with both requesting → loader granted every cycle, cpu_stall = 1.
- Then drop rst low mid-read → all outputs 0 immediately.
